// File: rtl/traffic_pkg.sv
// Shared state codes, lamp encodings and default timing for the traffic light controller.
// The pedestrian phase exists only when TRAFFIC_PED_WALK_EN is defined.
package traffic_pkg;

    typedef enum logic [2:0] {
        ALLRED_A  = 3'd0,
        NS_GREEN  = 3'd1,
        NS_YELLOW = 3'd2,
        ALLRED_B  = 3'd3,
        EW_GREEN  = 3'd4,
        EW_YELLOW = 3'd5,
        PED_WALK  = 3'd6,
        BAD_CODE  = 3'd7
    } tl_state_e;

    localparam logic [2:0] LAMP_RED    = 3'b100;
    localparam logic [2:0] LAMP_YELLOW = 3'b010;
    localparam logic [2:0] LAMP_GREEN  = 3'b001;

    localparam int DEF_GREEN_T     = 10;
    localparam int DEF_YELLOW_T    = 3;
    localparam int DEF_ALLRED_T    = 1;
    localparam int DEF_MIN_GREEN_T = 4;
    localparam int DEF_WALK_T      = 5;

    typedef struct packed {
        logic [2:0] ns;
        logic [2:0] ew;
        logic       walk;
    } lamps_t;

    // Anything that is not a green/yellow phase shows red both ways.
    function automatic lamps_t decode_lamps(input tl_state_e s);
        lamps_t l;
        l.ns   = LAMP_RED;
        l.ew   = LAMP_RED;
        l.walk = 1'b0;
        case (s)
            NS_GREEN:  l.ns   = LAMP_GREEN;
            NS_YELLOW: l.ns   = LAMP_YELLOW;
            EW_GREEN:  l.ew   = LAMP_GREEN;
            EW_YELLOW: l.ew   = LAMP_YELLOW;
            PED_WALK:  l.walk = 1'b1;
            default:   ;
        endcase
        return l;
    endfunction

endpackage

// File: rtl/tick_timer.sv
// Per-state down-counter: loads a duration, decrements once per tick, and flags
// the tick on which the current state's time runs out.
module tick_timer #(
    parameter int RESET_VAL = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       load,
    input  logic [7:0] load_val,
    output logic [7:0] remain,
    output logic       expire
);

    logic [7:0] remain_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            remain_reg <= 8'(RESET_VAL);
        end else if (load) begin
            remain_reg <= load_val;
        end else if (tick && remain_reg != 8'd0) begin
            remain_reg <= remain_reg - 8'd1;
        end
    end

    assign remain = remain_reg;
    assign expire = tick && (remain_reg == 8'd1);

endmodule

// File: rtl/traffic_light_ctrl.sv
// Two-way intersection controller with all-red clearance and optional pedestrian phase.
// Define TRAFFIC_PED_WALK_EN to build the pedestrian request/walk logic.
module traffic_light_ctrl
    import traffic_pkg::*;
#(
    parameter int GREEN_T     = DEF_GREEN_T,
    parameter int YELLOW_T    = DEF_YELLOW_T,
    parameter int ALLRED_T    = DEF_ALLRED_T,
    parameter int MIN_GREEN_T = DEF_MIN_GREEN_T,
    parameter int WALK_T      = DEF_WALK_T
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       ped_req,
    output logic [2:0] ns_light,
    output logic [2:0] ew_light,
    output logic       walk,
    output logic [2:0] state,
    output logic [7:0] remain
);

    // A pending request may cut green short once remain has fallen to this value.
    localparam logic [7:0] CUT_AT = 8'(GREEN_T - MIN_GREEN_T + 1);

    tl_state_e  state_reg, state_next;
    logic       go;
    logic       expire;
    logic       ped_cut;
    logic       ped_sel;
    logic [2:0] ns_light_reg, ew_light_reg;
    logic       walk_reg;
    lamps_t     lamps_next;

`ifdef TRAFFIC_PED_WALK_EN
    localparam bit WALK_EN = 1'b1;
    logic ped_pend_reg;

    assign ped_cut = tick && ped_pend_reg && (remain <= CUT_AT);
    assign ped_sel = ped_pend_reg;

    // Entry into the walk phase consumes the request, even if the button is still held.
    always_ff @(posedge clk) begin
        if (rst) begin
            ped_pend_reg <= 1'b0;
        end else if (go && state_next == PED_WALK) begin
            ped_pend_reg <= 1'b0;
        end else if (ped_req && state_reg != PED_WALK) begin
            ped_pend_reg <= 1'b1;
        end
    end
`else
    localparam bit WALK_EN = 1'b0;
    logic ped_req_unused;

    assign ped_req_unused = ped_req;
    assign ped_cut        = 1'b0;
    assign ped_sel        = 1'b0;
`endif

    function automatic logic [7:0] state_dur(input tl_state_e s);
        case (s)
            NS_GREEN, EW_GREEN:   return 8'(GREEN_T);
            NS_YELLOW, EW_YELLOW: return 8'(YELLOW_T);
            PED_WALK:             return 8'(WALK_T);
            default:              return 8'(ALLRED_T);
        endcase
    endfunction

    always_comb begin
        state_next = state_reg;
        go         = 1'b0;
        case (state_reg)
            ALLRED_A: if (expire) begin
                go         = 1'b1;
                state_next = ped_sel ? PED_WALK : NS_GREEN;
            end
            NS_GREEN: if (expire || ped_cut) begin
                go         = 1'b1;
                state_next = NS_YELLOW;
            end
            NS_YELLOW: if (expire) begin
                go         = 1'b1;
                state_next = ALLRED_B;
            end
            ALLRED_B: if (expire) begin
                go         = 1'b1;
                state_next = EW_GREEN;
            end
            EW_GREEN: if (expire || ped_cut) begin
                go         = 1'b1;
                state_next = EW_YELLOW;
            end
            EW_YELLOW: if (expire) begin
                go         = 1'b1;
                state_next = ALLRED_A;
            end
            PED_WALK: if (expire) begin
                go         = 1'b1;
                state_next = NS_GREEN;
            end
            default: begin
                go         = 1'b1;
                state_next = ALLRED_A;
            end
        endcase
    end

    assign lamps_next = decode_lamps(state_next);

    // Lamps are registered alongside the state so both change on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= ALLRED_A;
            ns_light_reg <= LAMP_RED;
            ew_light_reg <= LAMP_RED;
            walk_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            ns_light_reg <= lamps_next.ns;
            ew_light_reg <= lamps_next.ew;
            walk_reg     <= WALK_EN && lamps_next.walk;
        end
    end

    tick_timer #(
        .RESET_VAL (ALLRED_T)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .tick     (tick),
        .load     (go),
        .load_val (state_dur(state_next)),
        .remain   (remain),
        .expire   (expire)
    );

    assign state    = state_reg;
    assign ns_light = ns_light_reg;
    assign ew_light = ew_light_reg;
    assign walk     = walk_reg;

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// Randomized bench for traffic_light_ctrl against a tick-level phase model.
// Follows TRAFFIC_PED_WALK_EN so the same bench covers both builds.
module tb_traffic_light_ctrl;

    localparam int GREEN_T     = 10;
    localparam int YELLOW_T    = 3;
    localparam int ALLRED_T    = 1;
    localparam int MIN_GREEN_T = 4;
    localparam int WALK_T      = 5;
`ifdef TRAFFIC_PED_WALK_EN
    localparam bit PED_EN = 1'b1;
`else
    localparam bit PED_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tick = 1'b0;
    logic       ped_req = 1'b0;
    logic [2:0] ns_light, ew_light, state;
    logic       walk;
    logic [7:0] remain;

    always #5 clk = ~clk;

    traffic_light_ctrl #(
        .GREEN_T     (GREEN_T),
        .YELLOW_T    (YELLOW_T),
        .ALLRED_T    (ALLRED_T),
        .MIN_GREEN_T (MIN_GREEN_T),
        .WALK_T      (WALK_T)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .tick     (tick),
        .ped_req  (ped_req),
        .ns_light (ns_light),
        .ew_light (ew_light),
        .walk     (walk),
        .state    (state),
        .remain   (remain)
    );

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    // Phase order: all-red A, NS green, NS yellow, all-red B, EW green, EW yellow, walk.
    int dur [7] = '{ALLRED_T, GREEN_T, YELLOW_T, ALLRED_T, GREEN_T, YELLOW_T, WALK_T};
    int m_st   = 0;
    int m_left = ALLRED_T;
    bit m_pend = 1'b0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int phase_after(input int s, input bit pend);
        case (s)
            0:       return pend ? 6 : 1;
            5:       return 0;
            6:       return 1;
            default: return s + 1;
        endcase
    endfunction

    function automatic int lamp_ns(input int s);
        return (s == 1) ? 1 : (s == 2) ? 2 : 4;
    endfunction

    function automatic int lamp_ew(input int s);
        return (s == 4) ? 1 : (s == 5) ? 2 : 4;
    endfunction

    task automatic model_step(input bit r, input bit t, input bit p);
        bit moved;
        int nxt;
        if (r) begin
            m_st   = 0;
            m_left = ALLRED_T;
            m_pend = 1'b0;
            return;
        end
        moved = 1'b0;
        nxt   = m_st;
        if (t) begin
            if (m_left == 1) begin
                moved = 1'b1;
                nxt   = phase_after(m_st, m_pend);
            end else if (PED_EN && m_pend && (m_st == 1 || m_st == 4) &&
                         (GREEN_T - m_left + 1 >= MIN_GREEN_T)) begin
                moved = 1'b1;
                nxt   = m_st + 1;
            end else begin
                m_left--;
            end
        end
        if (PED_EN) begin
            if (moved && nxt == 6) m_pend = 1'b0;
            else if (p && m_st != 6) m_pend = 1'b1;
        end
        if (moved) begin
            m_st   = nxt;
            m_left = dur[nxt];
        end
    endtask

    task automatic cycle(input bit r, input bit t, input bit p);
        int prev;
        prev = m_st;
        @(negedge clk);
        rst     = r;
        tick    = t;
        ped_req = p;
        model_step(r, t, p);
        @(posedge clk);
        #1;
        cyc++;
        if (prev != m_st)
            $display("cyc=%0d rst=%0b ped=%0b state %0d->%0d remain=%0d ns=%03b ew=%03b walk=%0b",
                     cyc, r, p, prev, m_st, remain, ns_light, ew_light, walk);
        check_val("state",  state,    m_st);
        check_val("remain", remain,   m_left);
        check_val("ns",     ns_light, lamp_ns(m_st));
        check_val("ew",     ew_light, lamp_ew(m_st));
        check_val("walk",   walk,     (m_st == 6) ? 1 : 0);
    endtask

    // One tick every fourth clock, as from the system divider.
    task automatic ticks(input int n, input bit p);
        for (int i = 0; i < n * 4; i++) cycle(1'b0, (i % 4) == 3, p);
    endtask

    task automatic run_until(input string tag, input int st, input int left);
        int budget;
        budget = 400;
        while (!(m_st == st && m_left == left) && budget > 0) begin
            cycle(1'b0, (cyc % 4) == 3, 1'b0);
            budget--;
        end
        check_val(tag, (m_st == st && m_left == left) ? 1 : 0, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset, then the plain six-phase cycle of 28 ticks.
        cycle(1'b1, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 1'b1);
        check_val("rst_state", state, 0);
        check_val("rst_remain", remain, ALLRED_T);
        ticks(1, 1'b0);
        check_val("first_green", state, 1);
        check_val("first_remain", remain, GREEN_T);
        ticks(27, 1'b0);
        check_val("cycle_back", state, 0);

        // Short request during NS green, then the resulting walk phase.
        run_until("reach_ns9", 1, 9);
        cycle(1'b0, 1'b0, 1'b1);
        ticks(40, 1'b0);

        // Button held across walk entry.
        run_until("reach_ew_y1", 5, 1);
        ticks(20, 1'b1);
        ticks(10, 1'b0);

        // Reset arriving together with a tick in EW yellow.
        run_until("reach_ew_y2", 5, 2);
        cycle(1'b1, 1'b1, 1'b0);
        check_val("rst_mid_state", state, 0);
        check_val("rst_mid_remain", remain, ALLRED_T);
        cycle(1'b0, 1'b0, 1'b0);

        // Random ticks, requests and occasional resets.
        for (int i = 0; i < 3000; i++)
            cycle($urandom_range(0, 199) == 0, $urandom_range(0, 2) == 0,
                  $urandom_range(0, 15) == 0);

        // Continuous request from a fresh reset.
        cycle(1'b1, 1'b0, 1'b1);
        ticks(60, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
